// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising two picorv32-style requesters onto one memory port.
// A per-transaction timeout completes a hung request with ERR_DATA and sets a sticky flag.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  r_valid,
   input  logic [1:0]  r_instr,
   input  logic [63:0] r_addr,
   input  logic [63:0] r_wdata,
   input  logic [7:0]  r_wstrb,
   output logic [1:0]  r_ready,
   output logic [31:0] r_rdata,
   output logic        m_valid,
   output logic        m_instr,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   output logic [3:0]  m_wstrb,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic        grant_id,
   output logic        timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

   // Wraps harmlessly when the timeout is disabled; w_expire is then forced low.
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);

   state_t           r_state;
   logic             r_prio;
   logic [CNT_W-1:0] r_cnt;
   logic             w_sel;
   logic             w_expire;

   // Grant choice in IDLE and timeout expiry detection in ISSUE.
   always_comb begin
      w_sel    = 1'b0;
      w_expire = 1'b0;
      if (r_valid == 2'b11) begin
         w_sel = r_prio;
      end else begin
         w_sel = r_valid[1];
      end
      if ((TIMEOUT_CYCLES != 32'd0) && (r_cnt == LP_CNT_LAST)) begin
         w_expire = 1'b1;
      end else begin
         w_expire = 1'b0;
      end
   end

   // Arbitration FSM with all outputs registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_prio      <= 1'b0;
         r_cnt       <= '0;
         r_ready     <= 2'b00;
         r_rdata     <= 32'h0000_0000;
         m_valid     <= 1'b0;
         m_instr     <= 1'b0;
         m_addr      <= 32'h0000_0000;
         m_wdata     <= 32'h0000_0000;
         m_wstrb     <= 4'b0000;
         grant_id    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (r_valid != 2'b00) begin
                  grant_id <= w_sel;
                  m_valid  <= 1'b1;
                  m_instr  <= r_instr[w_sel];
                  m_addr   <= w_sel ? r_addr[63:32]  : r_addr[31:0];
                  m_wdata  <= w_sel ? r_wdata[63:32] : r_wdata[31:0];
                  m_wstrb  <= w_sel ? r_wstrb[7:4]   : r_wstrb[3:0];
                  r_cnt    <= '0;
                  r_state  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // m_ready has precedence over a simultaneous expiry.
               if (m_ready) begin
                  r_rdata <= m_rdata;
                  r_ready <= grant_id ? 2'b10 : 2'b01;
                  m_valid <= 1'b0;
                  r_prio  <= ~grant_id;
                  r_state <= ST_RESP;
               end else if (w_expire) begin
                  r_rdata     <= ERR_DATA;
                  r_ready     <= grant_id ? 2'b10 : 2'b01;
                  m_valid     <= 1'b0;
                  timeout_err <= 1'b1;
                  r_prio      <= ~grant_id;
                  r_state     <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_RESP: begin
               r_ready <= 2'b00;
               r_state <= ST_IDLE;
            end
            default: begin
               r_ready <= 2'b00;
               m_valid <= 1'b0;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
